// File: rtl/md_sched_if.sv
// E-stage / stall-unit side bundle of the multiply/divide scheduler.
// The master drives the instruction inputs; the slave (md_sched) owns HI/LO and the stall request.
interface md_sched_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_is_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        md_stall;

  modport master (
    output start, md_op, src_a, src_b, d_is_md,
    input  busy, hi, lo, done, md_stall
  );

  modport slave (
    input  start, md_op, src_a, src_b, d_is_md,
    output busy, hi, lo, done, md_stall
  );
endinterface

// File: rtl/md_sched.sv
// Fixed-latency mult/div sequencer and HI/LO owner. The result is computed at the start edge
// and held in a pending register until the busy window of MULT_CYCLES or DIV_CYCLES closes.
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_sched_if.slave md
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt;
  logic [63:0] r_pend;
  logic [31:0] r_hi, r_lo;
  logic        r_done;

  logic        w_launch, w_commit, w_mthi, w_mtlo, w_busy;
  logic [7:0]  w_load;
  logic [63:0] w_result;
  logic [63:0] w_a_sx, w_b_sx, w_a_zx, w_b_zx;
  logic        w_div_zero, w_div_ovf;
  logic signed [31:0] w_sa, w_sb_safe, w_sq, w_sr;
  logic [31:0] w_ub_safe, w_uq, w_ur;

  assign w_a_sx = {{32{md.src_a[31]}}, md.src_a};
  assign w_b_sx = {{32{md.src_b[31]}}, md.src_b};
  assign w_a_zx = {32'h0, md.src_a};
  assign w_b_zx = {32'h0, md.src_b};

  // Divisor is forced to 1 in the special cases so the raw divider never sees /0 or INT_MIN/-1.
  assign w_div_zero = (md.src_b == 32'h0);
  assign w_div_ovf  = (md.src_a == 32'h8000_0000) && (md.src_b == 32'hFFFF_FFFF);
  assign w_sa       = md.src_a;
  assign w_sb_safe  = (w_div_zero || w_div_ovf) ? 32'sd1 : md.src_b;
  assign w_ub_safe  = w_div_zero ? 32'd1 : md.src_b;
  assign w_sq       = w_sa / w_sb_safe;
  assign w_sr       = w_sa % w_sb_safe;
  assign w_uq       = md.src_a / w_ub_safe;
  assign w_ur       = md.src_a % w_ub_safe;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_result = '0;
    case (md.md_op)
      3'd0: w_result = w_a_sx * w_b_sx;
      3'd1: w_result = w_a_zx * w_b_zx;
      3'd2: w_result = w_div_zero ? {md.src_a, 32'hFFFF_FFFF} :
                       w_div_ovf  ? {32'h0, 32'h8000_0000} : {w_sr, w_sq};
      3'd3: w_result = w_div_zero ? {md.src_a, 32'hFFFF_FFFF} : {w_ur, w_uq};
      default: w_result = '0;
    endcase
  end

  assign w_load = md.md_op[1] ? 8'(DIV_CYCLES - 1) : 8'(MULT_CYCLES - 1);

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_commit    = 1'b0;
    w_mthi      = 1'b0;
    w_mtlo      = 1'b0;
    case (r_state)
      IDLE: if (md.start) begin
        case (md.md_op)
          3'd0, 3'd1, 3'd2, 3'd3: begin
            w_launch    = 1'b1;
            w_state_nxt = RUN;
          end
          3'd4:    w_mthi = 1'b1;
          3'd5:    w_mtlo = 1'b1;
          default: ;
        endcase
      end
      RUN: if (r_cnt == 8'd0) begin
        w_commit    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_launch) begin
        r_pend <= w_result;
        r_cnt  <= w_load;
      end else if (r_state == RUN && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_commit) {r_hi, r_lo} <= r_pend;
      if (w_mthi)   r_hi <= md.src_a;
      if (w_mtlo)   r_lo <= md.src_a;
    end
  end

  assign w_busy      = (r_state == RUN);
  assign md.busy     = w_busy;
  assign md.hi       = r_hi;
  assign md.lo       = r_lo;
  assign md.done     = r_done;
  assign md.md_stall = md.d_is_md & (w_busy | md.start);
endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed corner cases then randomized MD traffic,
// compared against a 64-bit arithmetic reference model and a cycle-count busy model.
module tb_md_sched;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  md_sched_if md_if ();

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: wide arithmetic makes INT_MIN/-1 fall out naturally; only /0 needs a rule.
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Issues one MD instruction; intrude>0 raises start again in that busy cycle with intr_op.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic dmd, input int intrude, input logic [2:0] intr_op);
    logic [63:0] res;
    int n;
    @(negedge clk);
    md_if.start   = 1'b1;
    md_if.md_op   = op;
    md_if.src_a   = a;
    md_if.src_b   = b;
    md_if.d_is_md = dmd;
    #1 check("stall_start", md_if.md_stall, dmd);
    @(negedge clk);
    md_if.start = 1'b0;
    md_if.src_a = $urandom;
    md_if.src_b = $urandom;
    if (op <= 3'd3) begin
      n   = op[1] ? DIV_N : MULT_N;
      res = ref_md(op, a, b);
      for (int i = 1; i <= n; i++) begin
        if (i == intrude) begin
          md_if.start = 1'b1;
          md_if.md_op = intr_op;
          md_if.src_a = 32'h1;
        end else begin
          md_if.start = 1'b0;
        end
        #1;
        check("busy_high", md_if.busy, 1'b1);
        check("done_low_busy", md_if.done, 1'b0);
        check("stall_busy", md_if.md_stall, dmd);
        check("hi_hold", md_if.hi, exp_hi);
        check("lo_hold", md_if.lo, exp_lo);
        @(negedge clk);
      end
      md_if.start = 1'b0;
      exp_hi = res[63:32];
      exp_lo = res[31:0];
      #1;
      check("busy_end", md_if.busy, 1'b0);
      check("done_pulse", md_if.done, 1'b1);
      check("hi_result", md_if.hi, exp_hi);
      check("lo_result", md_if.lo, exp_lo);
      check("stall_after_done", md_if.md_stall, 1'b0);
      @(negedge clk);
      #1 check("done_one_cycle", md_if.done, 1'b0);
    end else begin
      if (op == 3'd4) exp_hi = a;
      if (op == 3'd5) exp_lo = a;
      #1;
      check("mt_busy", md_if.busy, 1'b0);
      check("mt_done", md_if.done, 1'b0);
      check("mt_hi", md_if.hi, exp_hi);
      check("mt_lo", md_if.lo, exp_lo);
    end
  endtask

  initial begin
    md_if.start   = 1'b0;
    md_if.md_op   = '0;
    md_if.src_a   = '0;
    md_if.src_b   = '0;
    md_if.d_is_md = 1'b0;
    #1;
    check("rst_busy", md_if.busy, 1'b0);
    check("rst_done", md_if.done, 1'b0);
    check("rst_hi", md_if.hi, 32'h0);
    check("rst_lo", md_if.lo, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    do_md(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 0, 3'd0);
    check("mult_hi_tp", md_if.hi, 32'hFFFF_FFFF);
    check("mult_lo_tp", md_if.lo, 32'hFFFF_FFFA);
    do_md(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 0, 3'd0);
    check("multu_hi_tp", md_if.hi, 32'h0000_0002);
    do_md(3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 0, 3'd0);
    check("div_lo_tp", md_if.lo, 32'hFFFF_FFFD);
    check("div_hi_tp", md_if.hi, 32'hFFFF_FFFF);
    do_md(3'd3, 32'h1234_5678, 32'h0, 1'b0, 0, 3'd0);
    check("divu0_lo_tp", md_if.lo, 32'hFFFF_FFFF);
    check("divu0_hi_tp", md_if.hi, 32'h1234_5678);
    do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 3'd0);
    check("ovf_lo_tp", md_if.lo, 32'h8000_0000);
    check("ovf_hi_tp", md_if.hi, 32'h0);
    do_md(3'd4, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 3'd0);
    do_md(3'd0, 32'd3, 32'd4, 1'b1, 2, 3'd5);
    check("ignored_hi_tp", md_if.hi, 32'h0);
    check("ignored_lo_tp", md_if.lo, 32'd12);
    do_md(3'd6, 32'h5555_5555, 32'h1, 1'b0, 0, 3'd0);
    do_md(3'd7, 32'hAAAA_AAAA, 32'h1, 1'b0, 0, 3'd0);

    // Abort a mult with reset in its third busy cycle.
    do_md(3'd4, 32'hCAFE_F00D, 32'h0, 1'b0, 0, 3'd0);
    do_md(3'd5, 32'h0BAD_F00D, 32'h0, 1'b0, 0, 3'd0);
    @(negedge clk);
    md_if.start = 1'b1;
    md_if.md_op = 3'd0;
    md_if.src_a = 32'd7;
    md_if.src_b = 32'd9;
    @(negedge clk);
    md_if.start = 1'b0;
    repeat (2) @(negedge clk);
    #1 check("pre_abort_busy", md_if.busy, 1'b1);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", md_if.busy, 1'b0);
    check("abort_hi", md_if.hi, 32'h0);
    check("abort_lo", md_if.lo, 32'h0);
    check("abort_done", md_if.done, 1'b0);
    exp_hi = '0;
    exp_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    repeat (MULT_N + 3) begin
      @(negedge clk);
      #1;
      check("no_ghost_done", md_if.done, 1'b0);
      check("no_ghost_busy", md_if.busy, 1'b0);
    end
    check("post_abort_lo", md_if.lo, 32'h0);

    repeat (40) begin
      logic [2:0] op, iop;
      logic [31:0] a, b;
      int intr;
      op   = 3'($urandom_range(0, 7));
      iop  = 3'($urandom_range(0, 7));
      a    = rnd_operand();
      b    = rnd_operand();
      intr = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DIV_N)) : 0;
      do_md(op, a, b, 1'($urandom_range(0, 1)), intr, iop);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
